axi4_memory: RTL and testbench



---
 rtl/axi4_memory_pkg.sv | 24 ++
 rtl/axi4_memory_parity.sv | 20 ++
 rtl/axi4_memory.sv | 106 ++++++++++
 tb/tb_axi4_memory.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/axi4_memory_pkg.sv
// Shared constants and access-type decoding for the axi4_memory SRAM model.
// Optional parity protection is enabled by defining AXI4_MEMORY_PARITY_EN.
package axi4_memory_pkg;

    localparam int AXI4_MEM_DATA_WIDTH = 32;
    localparam int AXI4_MEM_ADDR_WIDTH = 10;
    localparam int AXI4_MEM_DEPTH      = 1024;

    // Kind of access presented on the memory port in a given cycle.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    // Collapse the enable/write-enable pair into an access type.
    function automatic acc_e decode_access(input logic en, input logic we);
        if (!en) begin
            return ACC_IDLE;
        end
        return we ? ACC_WRITE : ACC_READ;
    endfunction

endpackage : axi4_memory_pkg

// File: rtl/axi4_memory_parity.sv
// Combinational even-parity generator (write side) and checker (read side)
// used by axi4_memory when AXI4_MEMORY_PARITY_EN is defined.
module axi4_memory_parity #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_par,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_par,
    output logic                  rd_err
);

    // Parity bit makes the XOR over data plus parity zero; flag a stored word
    // whose recomputed parity disagrees with the bit saved alongside it.
    always_comb begin
        wr_par = ^wr_data;
        rd_err = (^rd_data) != rd_par;
    end

endmodule : axi4_memory_parity

// File: rtl/axi4_memory.sv
// Single-port, word-addressed synchronous SRAM with a 1-cycle registered read.
// Define AXI4_MEMORY_PARITY_EN to add per-word even parity and the mem_perr output.
module axi4_memory
    import axi4_memory_pkg::*;
#(
    parameter int DATA_WIDTH = AXI4_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = AXI4_MEM_ADDR_WIDTH,
    parameter int DEPTH      = AXI4_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata
`ifdef AXI4_MEMORY_PARITY_EN
    ,
    output logic                  mem_perr
`endif
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];

    acc_e                  acc;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifdef AXI4_MEMORY_PARITY_EN
    logic parity_mem [0:DEPTH-1];
    logic wr_par;
    logic rd_err;
    logic perr_d;
    logic perr_q;

    axi4_memory_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .wr_data (mem_wdata),
        .wr_par  (wr_par),
        .rd_data (rd_word),
        .rd_par  (parity_mem[mem_addr]),
        .rd_err  (rd_err)
    );
`endif

    // Decode the access and fetch the addressed word; out-of-range reads return 0.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        acc      = decode_access(mem_en, mem_we);
        in_range = 32'(mem_addr) < DEPTH_U;
        rd_word  = memory[mem_addr];
        rdata_d  = rdata_q;
        if (acc == ACC_READ) begin
            rdata_d = in_range ? rd_word : '0;
        end
    end

`ifdef AXI4_MEMORY_PARITY_EN
    // Parity error flag follows the read path: updated only on reads, 0 out of range.
    always_comb begin
        perr_d = perr_q;
        if (acc == ACC_READ) begin
            perr_d = in_range ? rd_err : 1'b0;
        end
    end
`endif

    // Array write port; a write landing while reset is asserted is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array itself is never cleared on reset; only the read register is.
        if (!rst_n) begin
        end else if (acc == ACC_WRITE && in_range) begin
            memory[mem_addr] <= mem_wdata;
`ifdef AXI4_MEMORY_PARITY_EN
            parity_mem[mem_addr] <= wr_par;
`endif
        end
    end

    // Registered read data (and parity flag) with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops sample together.
        if (!rst_n) begin
            rdata_q <= '0;
`ifdef AXI4_MEMORY_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            rdata_q <= rdata_d;
`ifdef AXI4_MEMORY_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign mem_rdata = rdata_q;
`ifdef AXI4_MEMORY_PARITY_EN
    assign mem_perr  = perr_q;
`endif

endmodule : axi4_memory

// File: tb/tb_axi4_memory.sv
// Self-checking bench for axi4_memory: random and directed traffic checked
// against a behavioural array model. Define AXI4_MEMORY_PARITY_EN to also
// exercise the parity output.
module tb_axi4_memory;
    import axi4_memory_pkg::*;

    localparam int DW    = AXI4_MEM_DATA_WIDTH;
    localparam int AW    = AXI4_MEM_ADDR_WIDTH;
    localparam int DEPTH = AXI4_MEM_DEPTH;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          mem_en = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
`ifdef AXI4_MEMORY_PARITY_EN
    logic          mem_perr;
`endif

    // Behavioural reference: plain array plus the value mem_rdata must show.
    logic [DW-1:0] model_mem [0:DEPTH-1];
    logic [DW-1:0] exp_rdata = '0;

    int errors = 0;
    int checks = 0;

    axi4_memory DUT (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef AXI4_MEMORY_PARITY_EN
        ,
        .mem_perr  (mem_perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One access cycle: drive, apply the spec rules to the model at the edge,
    // then confirm the array after the edge when a write was attempted.
    task automatic drive(input logic en, input logic we, input int addr, input logic [DW-1:0] wdata);
        mem_en    = en;
        mem_we    = we;
        mem_addr  = AW'(addr);
        mem_wdata = wdata;
        @(posedge clk);
        if (!rst_n) begin
            exp_rdata = '0;
        end else if (en) begin
            if (we) begin
                if (addr < DEPTH) model_mem[addr] = wdata;
            end else begin
                exp_rdata = (addr < DEPTH) ? model_mem[addr] : '0;
            end
        end
        @(negedge clk);
        if (en && we) check("mem_write", DUT.memory[addr], model_mem[addr]);
    endtask

    // Read data must match the model on every cycle, reads and holds alike.
    always @(negedge clk) begin
        check("rdata", mem_rdata, exp_rdata);
    end

    initial begin
        logic [DW-1:0] prior;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        #1 rst_n = 1'b0;
        #1 check("reset_initial", mem_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fill of all but the top word.
        for (int a = 0; a < DEPTH - 1; a++) drive(1'b1, 1'b1, a, $urandom);

        // Sequential readback.
        for (int a = 0; a < DEPTH - 1; a++) drive(1'b1, 1'b0, a, $urandom);

        // Disabled write leaves the array and read data alone.
        prior = model_mem[5];
        drive(1'b0, 1'b1, 5, 32'd200);
        check("disabled_write", DUT.memory[5], prior);

        // Back-to-back write then read of the top address.
        drive(1'b1, 1'b1, DEPTH - 1, 32'hDEADBEEF);
        drive(1'b1, 1'b0, DEPTH - 1, 32'h0);
        check("b2b_read", mem_rdata, 32'hDEADBEEF);

        // Hand-computed pin: write, idle with junk, read back.
        drive(1'b1, 1'b1, 10, 32'h12345678);
        drive(1'b0, 1'b1, 10, 32'hFFFFFFFF);
        check("idle_keeps_word", DUT.memory[10], 32'h12345678);
        drive(1'b1, 1'b0, 10, 32'h0);
        check("pinned_read", mem_rdata, 32'h12345678);

        // Mid-cycle asynchronous reset with a write attempted during it.
        #2 rst_n = 1'b0;
        exp_rdata = '0;
        #1 check("reset_async", mem_rdata, 32'h0);
        prior = model_mem[3];
        drive(1'b1, 1'b1, 3, ~prior);
        check("write_in_reset", DUT.memory[3], prior);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 0, 32'h0);
        check("rdata_zero_after_release", mem_rdata, 32'h0);
        for (int i = 0; i < DEPTH; i++) check("array_kept", DUT.memory[i], model_mem[i]);

        // Randomised mixed traffic.
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH - 1)), $urandom);
        end

`ifdef AXI4_MEMORY_PARITY_EN
        drive(1'b1, 1'b1, 7, 32'h00000001);
        DUT.memory[7] = DUT.memory[7] ^ 32'h1;
        model_mem[7]  = model_mem[7] ^ 32'h1;
        drive(1'b1, 1'b0, 7, 32'h0);
        check("perr_corrupt", 32'(mem_perr), 32'h1);
        drive(1'b1, 1'b1, 12, 32'h00000003);
        drive(1'b1, 1'b0, 12, 32'h0);
        check("perr_clean", 32'(mem_perr), 32'h0);
`endif

        drive(1'b0, 1'b0, 0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi4_memory
